// File: rtl/modif_sender.sv
// Frame sender for the ModifChk dirty range: freezes the range via in_send, reads it from the
// shadow buffer and streams sync/start/length/data/checksum bytes over a valid/ready link.
module modif_sender #(
    parameter int          AW      = 8,
    parameter logic [7:0]  SYNC    = 8'hA5,
    parameter int          MIN_GAP = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          is_modif,
    input  logic [AW-1:0] modif_start,
    input  logic [AW-1:0] modif_end,
    output logic          in_send,
    output logic          rd_stb,
    output logic [AW-1:0] rd_addr,
    input  logic [7:0]    rd_data,
    output logic [7:0]    tx_data,
    output logic          tx_valid,
    input  logic          tx_ready,
    output logic          busy
);

    localparam int GW = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(MIN_GAP - 1);

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_ARM    = 4'd1,
        ST_SYNC   = 4'd2,
        ST_HSTART = 4'd3,
        ST_HLEN   = 4'd4,
        ST_RD     = 4'd5,
        ST_RDW    = 4'd6,
        ST_DAT    = 4'd7,
        ST_CSUM   = 4'd8,
        ST_GAP    = 4'd9
    } state_t;

    function automatic logic [7:0] zext(input logic [AW-1:0] v);
        logic [7:0] r;
        r        = 8'h00;
        r[AW-1:0] = v;
        return r;
    endfunction

    function automatic logic [7:0] csum_add(input logic [7:0] sum, input logic [7:0] b);
        return sum + b;
    endfunction

    state_t        state_r, state_s;
    logic [AW-1:0] s_r, e_r, addr_r, addr_s;
    logic [7:0]    sum_r, sum_s;
    logic [7:0]    tx_data_r, tx_data_s;
    logic [GW-1:0] gap_cnt_r;
    logic          in_send_r, rd_stb_r, tx_valid_r, busy_r;
    logic [AW-1:0] rd_addr_r;
    logic          hs_s;

    assign hs_s     = tx_valid_r & tx_ready;
    assign in_send  = in_send_r;
    assign rd_stb   = rd_stb_r;
    assign rd_addr  = rd_addr_r;
    assign tx_data  = tx_data_r;
    assign tx_valid = tx_valid_r;
    assign busy     = busy_r;

    // Next-state, next byte, running checksum and address sequencing.
    always_comb begin
        state_s   = state_r;
        addr_s    = addr_r;
        sum_s     = sum_r;
        tx_data_s = tx_data_r;
        case (state_r)
            ST_IDLE: begin
                if (en && is_modif) state_s = ST_ARM;
                else                state_s = ST_IDLE;
            end
            ST_ARM: begin
                state_s   = ST_SYNC;
                addr_s    = modif_start;
                sum_s     = 8'h00;
                tx_data_s = SYNC;
            end
            ST_SYNC: begin
                if (hs_s) begin
                    state_s   = ST_HSTART;
                    tx_data_s = zext(s_r);
                end else begin
                    state_s = ST_SYNC;
                end
            end
            ST_HSTART: begin
                if (hs_s) begin
                    state_s   = ST_HLEN;
                    sum_s     = csum_add(sum_r, tx_data_r);
                    tx_data_s = zext(e_r - s_r);
                end else begin
                    state_s = ST_HSTART;
                end
            end
            ST_HLEN: begin
                if (hs_s) begin
                    state_s = ST_RD;
                    sum_s   = csum_add(sum_r, tx_data_r);
                end else begin
                    state_s = ST_HLEN;
                end
            end
            ST_RD:  state_s = ST_RDW;
            ST_RDW: begin
                state_s   = ST_DAT;
                tx_data_s = rd_data;
            end
            ST_DAT: begin
                if (hs_s) begin
                    sum_s = csum_add(sum_r, tx_data_r);
                    // Termination by compare keeps a full-buffer range from wrapping.
                    if (addr_r == e_r) begin
                        state_s   = ST_CSUM;
                        tx_data_s = sum_s;
                    end else begin
                        state_s = ST_RD;
                        addr_s  = addr_r + AW'(1);
                    end
                end else begin
                    state_s = ST_DAT;
                end
            end
            ST_CSUM: begin
                if (hs_s) state_s = ST_GAP;
                else      state_s = ST_CSUM;
            end
            ST_GAP: begin
                if (gap_cnt_r == GAP_LAST) state_s = ST_IDLE;
                else                       state_s = ST_GAP;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State, datapath and registered outputs decoded from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            s_r        <= '0;
            e_r        <= '0;
            addr_r     <= '0;
            sum_r      <= 8'h00;
            tx_data_r  <= 8'h00;
            gap_cnt_r  <= '0;
            in_send_r  <= 1'b0;
            rd_stb_r   <= 1'b0;
            rd_addr_r  <= '0;
            tx_valid_r <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r   <= state_s;
            addr_r    <= addr_s;
            sum_r     <= sum_s;
            tx_data_r <= tx_data_s;
            if (state_r == ST_ARM) begin
                s_r <= modif_start;
                e_r <= modif_end;
            end
            if (state_r == ST_GAP && state_s == ST_GAP) gap_cnt_r <= gap_cnt_r + GW'(1);
            else                                        gap_cnt_r <= '0;
            in_send_r  <= (state_s != ST_IDLE) && (state_s != ST_GAP);
            busy_r     <= (state_s != ST_IDLE);
            tx_valid_r <= (state_s inside {ST_SYNC, ST_HSTART, ST_HLEN, ST_DAT, ST_CSUM});
            rd_stb_r   <= (state_s == ST_RD);
            if (state_s == ST_RD) rd_addr_r <= addr_s;
        end
    end

endmodule

// File: tb/tb_modif_sender.sv
// Directed bench for modif_sender: frame contents, read pulses, stalls, gap timing and enable gating.
module tb_modif_sender;

    localparam int MIN_GAP = 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       is_modif;
    logic [7:0] modif_start;
    logic [7:0] modif_end;
    logic       in_send;
    logic       rd_stb;
    logic [7:0] rd_addr;
    logic [7:0] rd_data = 8'h00;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;

    logic [7:0] mem [256];
    logic [7:0] rx_q [$];
    logic [7:0] rd_q [$];
    logic [7:0] exp_q [$];
    int         checks = 0;
    int         failures = 0;
    int         hi_cnt = 0;
    int         rise_cnt = 0;
    int         low_cnt;
    logic       prev_stall = 1'b0;
    logic       prev_in_send = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic       rand_ready = 1'b0;

    modif_sender #(.AW(8), .SYNC(8'hA5), .MIN_GAP(MIN_GAP)) dut (
        .clk(clk), .rst(rst), .en(en), .is_modif(is_modif),
        .modif_start(modif_start), .modif_end(modif_end),
        .in_send(in_send), .rd_stb(rd_stb), .rd_addr(rd_addr), .rd_data(rd_data),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    // Shadow buffer with one-cycle read latency.
    always @(posedge clk) begin
        if (rd_stb) rd_data <= mem[rd_addr];
    end

    // Randomised downstream ready, about 30% accept rate.
    always @(posedge clk) begin
        #1;
        if (rand_ready) tx_ready = ($urandom_range(0, 99) < 30);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Link monitor: collects accepted bytes, read addresses and in_send activity.
    always @(negedge clk) begin
        if (!rst) begin
            if (tx_valid && tx_ready) rx_q.push_back(tx_data);
            if (rd_stb) rd_q.push_back(rd_addr);
            if (in_send) hi_cnt++;
            if (in_send && !prev_in_send) rise_cnt++;
            if (prev_stall) begin
                chk("hold_valid", 32'(tx_valid), 32'd1);
                chk("hold_data", 32'(tx_data), 32'(prev_data));
            end
        end
        prev_stall   = tx_valid && !tx_ready && !rst;
        prev_data    = tx_data;
        prev_in_send = in_send;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_in_send(input string tag, input logic v);
        int n = 0;
        while (in_send !== v && n < 300) begin
            cyc(1);
            n++;
        end
        chk(tag, 32'(in_send), 32'(v));
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy !== 1'b0 && n < 2000) begin
            cyc(1);
            n++;
        end
        chk(tag, 32'(busy), 32'd0);
    endtask

    task automatic chk_frame(input string tag);
        chk({tag, "_len"}, 32'(rx_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            chk($sformatf("%s_b%0d", tag, i), 32'(rx_q[i]), 32'(exp_q[i]));
    endtask

    task automatic start_frame(input logic [7:0] s, input logic [7:0] e);
        modif_start = s;
        modif_end   = e;
        rx_q.delete();
        rd_q.delete();
        hi_cnt   = 0;
        rise_cnt = 0;
        is_modif = 1'b1;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; is_modif = 1'b0; tx_ready = 1'b0;
        modif_start = 8'h00; modif_end = 8'h00;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i);
        cyc(3);
        chk("rst_in_send", 32'(in_send), 32'd0);
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rd_stb", 32'(rd_stb), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'h00);
        chk("rst_rd_addr", 32'(rd_addr), 32'h00);
        rst = 1'b0;
        cyc(1);

        // Reset while stalled in a data byte.
        en = 1'b1; tx_ready = 1'b1;
        start_frame(8'h30, 8'h33);
        begin
            int n = 0;
            while (rd_stb !== 1'b1 && n < 100) begin cyc(1); n++; end
        end
        chk("t1_rd_stb", 32'(rd_stb), 32'd1);
        tx_ready = 1'b0;
        cyc(4);
        chk("t1_stall_valid", 32'(tx_valid), 32'd1);
        chk("t1_stall_data", 32'(tx_data), 32'h30);
        is_modif = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("t1_in_send", 32'(in_send), 32'd0);
        chk("t1_tx_valid", 32'(tx_valid), 32'd0);
        chk("t1_busy", 32'(busy), 32'd0);
        cyc(1);
        rst = 1'b0;
        rd_q.delete();
        cyc(20);
        chk("t1_no_rd", 32'(rd_q.size()), 32'd0);

        // Three-byte frame at 0x10..0x12, ready held high.
        tx_ready = 1'b1;
        start_frame(8'h10, 8'h12);
        wait_in_send("t2_start", 1'b1);
        is_modif = 1'b0;
        wait_idle("t2_done");
        exp_q = '{8'hA5, 8'h10, 8'h02, 8'h10, 8'h11, 8'h12, 8'h45};
        chk_frame("t2");
        chk("t2_rd_cnt", 32'(rd_q.size()), 32'd3);
        for (int i = 0; i < 3 && i < rd_q.size(); i++)
            chk($sformatf("t2_rd%0d", i), 32'(rd_q[i]), 32'h10 + 32'(i));
        chk("t2_in_send_cycles", 32'(hi_cnt), 32'd14);
        chk("t2_in_send_rises", 32'(rise_cnt), 32'd1);

        // Single byte at the top address, checksum wraps.
        mem[255] = 8'h80;
        start_frame(8'hFF, 8'hFF);
        wait_in_send("t3_start", 1'b1);
        is_modif = 1'b0;
        wait_idle("t3_done");
        exp_q = '{8'hA5, 8'hFF, 8'h00, 8'h80, 8'h7F};
        chk_frame("t3");
        chk("t3_rd_cnt", 32'(rd_q.size()), 32'd1);
        if (rd_q.size() > 0) chk("t3_rd0", 32'(rd_q[0]), 32'hFF);

        // Random backpressure gives the same bytes.
        rand_ready = 1'b1;
        start_frame(8'h10, 8'h12);
        wait_in_send("t4_start", 1'b1);
        is_modif = 1'b0;
        wait_idle("t4_done");
        rand_ready = 1'b0;
        tx_ready = 1'b1;
        exp_q = '{8'hA5, 8'h10, 8'h02, 8'h10, 8'h11, 8'h12, 8'h45};
        chk_frame("t4");

        // Write during a frame re-arms a second frame after the gap.
        cyc(2);
        start_frame(8'h05, 8'h08);
        wait_in_send("t5_start", 1'b1);
        wait_in_send("t5_end", 1'b0);
        exp_q = '{8'hA5, 8'h05, 8'h03, 8'h05, 8'h06, 8'h07, 8'h08, 8'h22};
        chk_frame("t5a");
        modif_start = 8'h20;
        modif_end   = 8'h20;
        rx_q.delete();
        low_cnt = 0;
        while (in_send !== 1'b1 && low_cnt < 20) begin
            low_cnt++;
            cyc(1);
        end
        chk("t5_gap", 32'(low_cnt), 32'(MIN_GAP + 1));
        is_modif = 1'b0;
        wait_idle("t5_done");
        exp_q = '{8'hA5, 8'h20, 8'h00, 8'h20, 8'h40};
        chk_frame("t5b");

        // Enable gating.
        cyc(2);
        en = 1'b0;
        start_frame(8'h40, 8'h40);
        cyc(100);
        chk("t6_no_send", 32'(hi_cnt), 32'd0);
        chk("t6_idle", 32'(busy), 32'd0);
        en = 1'b1;
        cyc(1);
        chk("t6_arm_in_send", 32'(in_send), 32'd1);
        chk("t6_arm_busy", 32'(busy), 32'd1);
        is_modif = 1'b0;
        wait_idle("t6_done");
        exp_q = '{8'hA5, 8'h40, 8'h00, 8'h40, 8'h80};
        chk_frame("t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
